// File: rtl/uart_mem_loader_pkg.sv
// rtl/uart_mem_loader_pkg.sv - shared state encoding and constants for the UART memory loader
//
// Purpose: loader FSM state encoding and the length-header width.
// Optional feature macro: LOADER_CHECKSUM_EN (no effect on this package).
package uart_mem_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_byte_packer.sv
// rtl/uart_byte_packer.sv - packs a byte stream into little-endian memory words
//
// Purpose: assembles WORD_BYTES bytes into a word; the finished word is copied
// into a holding register and announced with a one-cycle pulse on the clock
// after the completing byte, so the assembly register is free immediately.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous clear of byte index and assembly register
//   in_valid     byte strobe (already qualified by the caller)
//   in_byte      byte to place at the current lane
//   word_last    combinational: this in_valid completes a word
//   word_valid   registered one-cycle pulse, word_data is a new word
//   word_data    holding register, first byte in bits [7:0]; holds until next word
module uart_byte_packer #(
  parameter int WORD_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [7:0]              in_byte,
  output logic                    word_last,
  output logic                    word_valid,
  output logic [8*WORD_BYTES-1:0] word_data
);

  localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic [IDX_W-1:0]        idx;
  logic [8*WORD_BYTES-1:0] asm_q;
  logic [8*WORD_BYTES-1:0] asm_n;

  // Assembly register with the incoming byte merged into its lane.
  always_comb begin
    asm_n = asm_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (IDX_W'(i) == idx) begin
        asm_n[8*i +: 8] = in_byte;
      end
    end
  end

  assign word_last = in_valid && (idx == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      asm_q      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx   <= '0;
        asm_q <= '0;
      end else if (in_valid) begin
        if (word_last) begin
          idx        <= '0;
          asm_q      <= '0;
          word_data  <= asm_n;
          word_valid <= 1'b1;
        end else begin
          idx   <= idx + 1'b1;
          asm_q <= asm_n;
        end
      end
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - loads a length-prefixed UART byte stream into memory
//
// Purpose: takes a 2-byte little-endian length header (in words), then packs
// data bytes into words and writes them at BASE_ADDR, BASE_ADDR+1, ... (mod
// 2**ADDR_W). Signals completion so the processor can leave hold.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// and the o_chk_err output.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_start               arm pulse, taken only in S_IDLE / S_DONE
//   i_rx_dv, i_rx_byte    UART receiver byte strobe and byte
//   o_mem_we              one-cycle write strobe
//   o_mem_addr            write address (holds between writes)
//   o_mem_wdata           write data (holds between writes)
//   o_busy                load in progress
//   o_load_done           level, in S_DONE
//   o_len_err             header length exceeded capacity
//   o_word_cnt            words written in current load
//   o_chk_err             (LOADER_CHECKSUM_EN only) trailing byte mismatch
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_rx_dv,
  input  logic [7:0]              i_rx_byte,
  output logic                    o_mem_we,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [8*WORD_BYTES-1:0] o_mem_wdata,
  output logic                    o_busy,
  output logic                    o_load_done,
  output logic                    o_len_err,
  output logic [15:0]             o_word_cnt
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic                    o_chk_err
`endif
);

  localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] hdr_len;
  logic [LEN_W-1:0] pend;
  logic             hdr_big;
  logic             start_ok;
  logic             data_dv;
  logic             last_write;
  logic             word_last;
  logic             word_valid;

  assign start_ok = i_start && ((state == S_IDLE) || (state == S_DONE));
  assign hdr_len  = {i_rx_byte, len_q[7:0]};
  assign hdr_big  = 32'(hdr_len) > CAPACITY;

  // Words completed including one whose write strobe is in flight; a byte
  // arriving in the write cycle must already see that word as counted.
  assign pend       = word_cnt + LEN_W'(word_valid);
  assign data_dv    = i_rx_dv && (state == S_DATA) && (pend < len_q);
  assign last_write = word_valid && ((word_cnt + LEN_W'(1)) == len_q);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  logic       trail_dv;
  // Once every word is in, the next byte in S_DATA is the checksum.
  assign trail_dv = i_rx_dv && (state == S_DATA) && (pend == len_q);
`endif

  uart_byte_packer #(
    .WORD_BYTES(WORD_BYTES)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .in_valid  (data_dv),
    .in_byte   (i_rx_byte),
    .word_last (word_last),
    .word_valid(word_valid),
    .word_data (o_mem_wdata)
  );

  assign o_mem_we   = word_valid;
  assign o_word_cnt = word_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n     = state;
    o_busy      = 1'b0;
    o_load_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_ok) state_n = S_LEN_LO;
      end
      S_LEN_LO: begin
        o_busy = 1'b1;
        if (i_rx_dv) state_n = S_LEN_HI;
      end
      S_LEN_HI: begin
        o_busy = 1'b1;
        if (i_rx_dv) begin
          if (hdr_big) begin
            state_n = S_DONE;
          end else if (hdr_len == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_n = S_DATA;
`else
            state_n = S_DONE;
`endif
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        o_busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (trail_dv) state_n = S_DONE;
`else
        if (last_write) state_n = S_DONE;
`endif
      end
      S_DONE: begin
        o_load_done = 1'b1;
        if (start_ok) state_n = S_LEN_LO;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      word_cnt   <= '0;
      o_len_err  <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      if (start_ok) begin
        word_cnt  <= '0;
        o_len_err <= 1'b0;
      end else if (word_valid) begin
        word_cnt <= word_cnt + LEN_W'(1);
      end

      if (i_rx_dv && (state == S_LEN_LO)) begin
        len_q[7:0] <= i_rx_byte;
      end
      if (i_rx_dv && (state == S_LEN_HI)) begin
        len_q[15:8] <= i_rx_byte;
        o_len_err   <= hdr_big;
      end

      // Address is captured with the completing byte so it is stable for the
      // whole write cycle and holds afterwards.
      if (word_last) begin
        o_mem_addr <= ADDR_W'(BASE_ADDR) + ADDR_W'(pend);
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q     <= 8'h00;
      o_chk_err <= 1'b0;
    end else begin
      if (start_ok) begin
        chk_q     <= 8'h00;
        o_chk_err <= 1'b0;
      end else if (data_dv) begin
        chk_q <= chk_q ^ i_rx_byte;
      end else if (trail_dv) begin
        o_chk_err <= (i_rx_byte != chk_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - scoreboard bench for uart_mem_loader (WORD_BYTES=2, ADDR_W=8)
module tb_uart_mem_loader;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_rx_dv;
  logic [7:0]  i_rx_byte;
  logic        o_mem_we;
  logic [7:0]  o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic        o_busy;
  logic        o_load_done;
  logic        o_len_err;
  logic [15:0] o_word_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic        o_chk_err;
`endif

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  uart_mem_loader #(
    .WORD_BYTES(2),
    .ADDR_W    (8),
    .BASE_ADDR (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_rx_dv    (i_rx_dv),
    .i_rx_byte  (i_rx_byte),
    .o_mem_we   (o_mem_we),
    .o_mem_addr (o_mem_addr),
    .o_mem_wdata(o_mem_wdata),
    .o_busy     (o_busy),
    .o_load_done(o_load_done),
    .o_len_err  (o_len_err),
    .o_word_cnt (o_word_cnt)
`ifdef LOADER_CHECKSUM_EN
    ,
    .o_chk_err  (o_chk_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One input cycle: called and returns at a negedge.
  task automatic drive(input logic dv, input logic [7:0] b, input logic st);
    i_rx_dv   = dv;
    i_rx_byte = b;
    i_start   = st;
    @(negedge clk);
    i_rx_dv   = 1'b0;
    i_start   = 1'b0;
  endtask

  // Call immediately before driving the completing byte: write is due next cycle.
  task automatic expect_write(input logic [7:0] a, input logic [15:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100 && !o_load_done; i++) @(negedge clk);
    check(name, o_load_done, 1'b1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0h data=%0h", o_mem_addr, o_mem_wdata);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", o_mem_addr, e.addr);
          check("wr_data", o_mem_wdata, e.data);
          check("wr_cycle", cyc, e.cyc);
        end
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    i_start   = 1'b0;
    i_rx_dv   = 1'b0;
    i_rx_byte = 8'h00;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    check("rst_we", o_mem_we, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_load_done, 1'b0);
    check("rst_len_err", o_len_err, 1'b0);
    check("rst_cnt", o_word_cnt, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Bytes before start are ignored.
    drive(1'b1, 8'hAA, 1'b0);
    drive(1'b1, 8'hBB, 1'b0);
    check("idle_busy", o_busy, 1'b0);
    check("idle_done", o_load_done, 1'b0);

    // Basic load, back-to-back bytes, start pulse during S_DATA.
    drive(1'b0, 8'h00, 1'b1);
    check("start_busy", o_busy, 1'b1);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    expect_write(8'h00, 16'h2211);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b1);
    expect_write(8'h01, 16'h4433);
    drive(1'b1, 8'h44, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h44, 1'b0);
`endif
    wait_done("load1_done");
    check("load1_cnt", o_word_cnt, 16'd2);
    check("load1_busy", o_busy, 1'b0);
    check("load1_len_err", o_len_err, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("load1_chk_err", o_chk_err, 1'b0);
`endif
    drive(1'b1, 8'h99, 1'b0);
    check("done_hold_cnt", o_word_cnt, 16'd2);

    // Zero-length header.
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h00, 1'b0);
`endif
    wait_done("zero_done");
    check("zero_cnt", o_word_cnt, 16'd0);
    check("zero_len_err", o_len_err, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    check("zero_chk_err", o_chk_err, 1'b0);
`endif

    // Length 257 exceeds 256-word capacity.
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h01, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    wait_done("big_done");
    check("big_len_err", o_len_err, 1'b1);
    check("big_cnt", o_word_cnt, 16'd0);

    // Restart with a simultaneous byte (dropped); writes restart at base.
    drive(1'b1, 8'h03, 1'b1);
    check("restart_len_err_clr", o_len_err, 1'b0);
    check("restart_done_clr", o_load_done, 1'b0);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    expect_write(8'h00, 16'h6655);
    drive(1'b1, 8'h66, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check("hold_addr", o_mem_addr, 8'h00);
    check("hold_data", o_mem_wdata, 16'h6655);
    drive(1'b1, 8'h77, 1'b0);
    expect_write(8'h01, 16'h8877);
    drive(1'b1, 8'h88, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    drive(1'b1, 8'h45, 1'b0);
`endif
    wait_done("load2_done");
    check("load2_cnt", o_word_cnt, 16'd2);
`ifdef LOADER_CHECKSUM_EN
    check("load2_chk_err", o_chk_err, 1'b1);
`endif

    // Reset mid-S_DATA after three data bytes.
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b1, 8'h11, 1'b0);
    expect_write(8'h00, 16'h2211);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_we", o_mem_we, 1'b0);
    check("mid_rst_addr", o_mem_addr, 8'h00);
    check("mid_rst_data", o_mem_wdata, 16'h0000);
    check("mid_rst_busy", o_busy, 1'b0);
    check("mid_rst_done", o_load_done, 1'b0);
    check("mid_rst_cnt", o_word_cnt, 16'd0);
    drive(1'b1, 8'h44, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 8'h44, 1'b0);
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    check("post_rst_busy", o_busy, 1'b0);
    check("post_rst_cnt", o_word_cnt, 16'd0);
    check("pending_writes", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
